uart_tx_stream: RTL
===================

// Module: uart_tx_stream
// PURPOSE
//  Parametrised UART transmitter that drains a show-ahead-free (1-cycle read latency) byte FIFO.
//  Generalises the fixed 8N1 sender: runtime baud divisor, DATA_W 5..9, runtime parity (none/odd/even),
//  1 or 2 stop bits, programmable inter-frame gap. Sits between the TX FIFO and the board rs_tx pin.
// PARAMETERS
//  DATA_W    8   data bits per frame, legal 5..9, sent LSB first
//  DIV_W     16  width of baud_div
//  GAP_BITS  1   idle bit-times appended after stop bits, legal 0..15
// PORTS
//  clk          in   1       system clock (50 MHz board clock)
//  rst          in   1       synchronous, active-high reset
//  baud_div     in   DIV_W   clocks per bit; values 0/1 are treated as 2
//  cfg_parity   in   2       0 = none, 1 = odd, 2 = even, 3 = none
//  cfg_stop2    in   1       1 = two stop bits
//  fifo_empty   in   1       FIFO empty flag
//  fifo_rd_en   out  1       one-cycle pop strobe
//  fifo_rd_data in   DATA_W  FIFO read data, valid the cycle after fifo_rd_en
//  rs_tx        out  1       serial line, idle high
//  busy         out  1       high from READ through end of GAP
//  frame_done   out  1       one-cycle pulse at end of last stop bit
// BEHAVIOUR
//  Clock is clk. Reset is synchronous active-high: rst sampled on posedge clk.
//  Reset values: rs_tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, baud counter=0.
//  FSM states and transitions:
//  - IDLE: stays while fifo_empty=1. fifo_empty=0 -> READ.
//  - READ: fifo_rd_en=1 for exactly this cycle -> LOAD.
//  - LOAD: capture fifo_rd_data, baud_div (clamped), cfg_parity and cfg_stop2 into shadow regs;
//    rs_tx<=0; clear baud counter -> START. Config changes mid-frame have no effect.
//  - START, DATA, PARITY, STOP, GAP: each bit held exactly div clocks.
//    Baud tick = (cnt == div-1); cnt wraps to 0 on tick; cnt is held at 0 in IDLE/READ/LOAD.
//  - START: tick -> DATA (rs_tx<=d[0]).
//  - DATA: bit index 0..DATA_W-1. Tick on the last index -> PARITY if enabled, else STOP.
//  - PARITY: even: rs_tx = ^d. Odd: rs_tx = ~^d.
//  - STOP: rs_tx=1 for 1 or 2 bit-times. On the final stop tick: frame_done=1 for 1 cycle;
//    go to GAP if GAP_BITS>0, else IDLE.
//  - GAP: rs_tx=1 for GAP_BITS bit-times -> IDLE.
//  Frame length from START edge = div*(1+DATA_W+P+S) clocks; gap adds div*GAP_BITS.
//  Back-to-back frames: fixed 3-cycle overhead (IDLE, READ, LOAD) between the end of STOP/GAP
//    and the next start bit; rs_tx stays 1 throughout.
//  fifo_empty is ignored outside IDLE; no pop is ever issued while busy.
//  Sync reset asserted mid-frame: rs_tx=1 on the next edge; the popped byte is discarded
//    (no re-read). Line may show a truncated frame; this is acceptable.
//  busy = (state != IDLE). Outputs are registered (no comb path from inputs to rs_tx or fifo_rd_en).
// STRUCTURE
//  Package uart_pkg: parity encodings (PAR_NONE/ODD/EVEN), tx state enum, bit-count widths.
//  Sub-module uart_baud_gen (clk, rst, en, div, tick): clamp, counter, tick. Reusable by the RX side.
//  FSM, shift register and parity live in uart_tx_stream.
// TESTING
//  - Reset: rst=1 for 3 cycles -> rs_tx=1, fifo_rd_en=0, busy=0, frame_done=0.
//  - 8N1, baud_div=4, FIFO holds 0x55, GAP_BITS=0:
//    -> one rd_en pulse; rs_tx = 0,1,0,1,0,1,0,1,0,1, each held 4 clocks (40 clocks).
//    -> frame_done 40 clocks after the falling start edge.
//  - Parity and stop bits, baud_div=3, 0x07:
//    -> odd: parity bit 0. Even: parity bit 1.
//    -> cfg_stop2=1: stop high for 6 clocks before frame_done.
//  - Back-to-back, FIFO holds 0xA5,0x3C, GAP_BITS=2, baud_div=4:
//    -> second start bit exactly 8+3 clocks after the first frame_done.
//    -> exactly 2 rd_en pulses.
//  - baud_div=0 and baud_div=1 -> each bit lasts 2 clocks; cfg change mid-frame -> current frame unchanged.
//  - rst asserted during DATA bit 3 -> rs_tx=1 next edge, state IDLE.
//    -> with fifo_empty=0, a new READ occurs 1 cycle after reset deasserts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity encodings, the
// transmitter state enum and counter widths.
package uart_pkg;

    // cfg_parity encodings; 2'd3 also means no parity
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Bit index covers up to 9 data bits; gap index covers up to 15 bit-times
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned GAP_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6,
        ST_GAP    = 3'd7
    } tx_state_e;

    // True when a parity bit is appended to the frame
    function automatic logic parity_on(input logic [1:0] par);
        return (par == PAR_ODD) || (par == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts clocks per bit while enabled.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   en        count enable; the counter is held at 0 while low
//   div       clocks per bit; 0 and 1 are treated as 2
//   tick      high on the last clock of each bit period
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Clamp divisor, detect end of bit, wrap counter on tick
    always_comb begin
        div_eff = (div < DIV_W'(2)) ? DIV_W'(2) : div;
        tick    = en && (cnt_q == (div_eff - DIV_W'(1)));
        cnt_d   = (!en || tick) ? '0 : (cnt_q + DIV_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter draining a 1-cycle-latency byte FIFO onto rs_tx.
// Runtime divisor, parity and stop-bit count are latched per frame.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   baud_div      clocks per bit (0/1 treated as 2)
//   cfg_parity    0/3 none, 1 odd, 2 even
//   cfg_stop2     1 = two stop bits
//   fifo_empty    FIFO empty flag, looked at only in IDLE
//   fifo_rd_en    one-cycle pop strobe
//   fifo_rd_data  FIFO data, valid the cycle after fifo_rd_en
//   rs_tx         serial line, idle high
//   busy          high whenever the FSM is not IDLE
//   frame_done    one-cycle pulse at the end of the last stop bit
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned GAP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              rs_tx,
    output logic              busy,
    output logic              frame_done
);

    tx_state_e             state_q, state_d;
    logic [DATA_W-1:0]     sh_q, sh_d;
    logic                  par_bit_q, par_bit_d;
    logic [1:0]            par_cfg_q, par_cfg_d;
    logic                  stop2_q, stop2_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_CNT_W-1:0]  bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [GAP_CNT_W-1:0]  gap_idx_q, gap_idx_d;
    logic                  rs_tx_q, rs_tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  done_q, done_d;
    logic                  busy_q;

    logic                  baud_en_c, tick_c;
    logic                  last_bit_c, last_stop_c, last_gap_c, par_en_c;

    // Baud counter runs only across the serial bit states
    assign baud_en_c = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_GAP};

    // Raw divisor is shadowed; clamping happens inside the generator
    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (baud_en_c),
        .div  (div_q),
        .tick (tick_c)
    );

    assign last_bit_c  = (bit_idx_q == BIT_CNT_W'(DATA_W - 1));
    assign last_stop_c = !stop2_q || stop_idx_q;
    assign last_gap_c  = (gap_idx_q == GAP_CNT_W'(GAP_BITS - 1));
    assign par_en_c    = parity_on(par_cfg_q);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            par_bit_q  <= 1'b0;
            par_cfg_q  <= PAR_NONE;
            stop2_q    <= 1'b0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            gap_idx_q  <= '0;
            rs_tx_q    <= 1'b1;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            par_bit_q  <= par_bit_d;
            par_cfg_q  <= par_cfg_d;
            stop2_q    <= stop2_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            gap_idx_q  <= gap_idx_d;
            rs_tx_q    <= rs_tx_d;
            rd_en_q    <= rd_en_d;
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_READ;
            ST_READ:   state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  if (tick_c) state_d = ST_DATA;
            ST_DATA:   if (tick_c && last_bit_c) state_d = par_en_c ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick_c) state_d = ST_STOP;
            ST_STOP:   if (tick_c && last_stop_c) state_d = (GAP_BITS != 0) ? ST_GAP : ST_IDLE;
            ST_GAP:    if (tick_c && last_gap_c) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the line, strobes and per-frame shadow registers
    always_comb begin
        sh_d       = sh_q;
        par_bit_d  = par_bit_q;
        par_cfg_d  = par_cfg_q;
        stop2_d    = stop2_q;
        div_d      = div_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        gap_idx_d  = gap_idx_q;
        rs_tx_d    = rs_tx_q;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rs_tx_d = 1'b1;
                if (!fifo_empty) rd_en_d = 1'b1;
            end
            ST_LOAD: begin
                sh_d       = fifo_rd_data;
                par_bit_d  = (cfg_parity == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
                par_cfg_d  = cfg_parity;
                stop2_d    = cfg_stop2;
                div_d      = baud_div;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                gap_idx_d  = '0;
                rs_tx_d    = 1'b0;
            end
            ST_START: begin
                if (tick_c) rs_tx_d = sh_q[0];
            end
            ST_DATA: begin
                // sh_q[0] is the bit currently on the line
                if (tick_c) begin
                    if (last_bit_c) begin
                        rs_tx_d = par_en_c ? par_bit_q : 1'b1;
                    end else begin
                        rs_tx_d   = sh_q[1];
                        sh_d      = sh_q >> 1;
                        bit_idx_d = bit_idx_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick_c) rs_tx_d = 1'b1;
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (last_stop_c) done_d = 1'b1;
                    else             stop_idx_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (tick_c) gap_idx_d = gap_idx_q + GAP_CNT_W'(1);
            end
            default: ;
        endcase
    end

    assign rs_tx      = rs_tx_q;
    assign fifo_rd_en = rd_en_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule
